dct_cos_term_gen: RTL and testbench
===================================

// Module: dct_cos_term_gen
// PURPOSE
// - Streams the 2-D DCT basis terms cos((2n1+1)k1*pi/2N) * cos((2n2+1)k2*pi/2N) for one (k1,k2) pair.
// - Covers all N*N (n1,n2) positions as a back-pressured stream.
// - Replaces the per-(k1,k2) hard-coded lookup modules with one parametrised sequential generator.
// - Feeds the DCT multiply-accumulate datapath, one term per accepted beat.
// PARAMETERS
// - N         8   block size per axis; power of 2, 2..32
// - FRAC_BITS 8   fractional bits of the fixed-point cosine (1.0 = 2**FRAC_BITS)
// - OUT_W     32  cos_term width; two's complement, sign-extended; must be >= FRAC_BITS+2
// PORTS
// - clk        in   1           rising-edge clock
// - reset      in   1           synchronous, active-high reset
// - start      in   1           request a sweep; sampled only when busy==0
// - k1         in   $clog2(N)   row frequency; captured when start is accepted
// - k2         in   $clog2(N)   column frequency; captured when start is accepted
// - busy       out  1           1 from the cycle after start is accepted until the last beat is accepted
// - out_valid  out  1           cos_term/n1/n2/last are valid
// - out_ready  in   1           consumer accepts a beat when out_valid && out_ready
// - cos_term   out  OUT_W       signed basis term, FRAC_BITS fractional bits
// - n1         out  $clog2(N)   spatial row index of this beat
// - n2         out  $clog2(N)   spatial column index of this beat
// - last       out  1           1 on beat (N-1,N-1), the final beat of the sweep
// - done       out  1           one-cycle pulse in the cycle after the last beat is accepted
// BEHAVIOUR
// - Reset: busy, out_valid, last and done = 0; cos_term, n1 and n2 = 0.
//   - FSM returns to IDLE and the index counters clear on the same edge.
//   - Applies identically mid-sweep; the partial sweep is discarded and no done pulse is issued.
// - Cosine ROM: C[k][n] = round_to_nearest(2**FRAC_BITS * cos((2n+1)*k*pi/(2N))).
//   - Holds N*N signed entries of FRAC_BITS+2 bits.
//   - Built at elaboration by a constant function; no run-time trig.
//   - Row k=0 is all 2**FRAC_BITS.
// - Term: cos_term = sign_extend((C[k1][n1] * C[k2][n2]) >>> FRAC_BITS).
//   - Full-width signed product, then arithmetic shift right (truncates toward -inf).
// - FSM states and transitions:
//   - IDLE: start=1 latches k1/k2, clears the issue counters, goes to RUN; busy=1 next cycle.
//   - RUN: issues one (n1,n2) per enabled cycle, raster order (n2 fastest).
//     - After issuing (N-1,N-1), goes to DRAIN.
//   - DRAIN: waits until the last beat is accepted, then pulses done and returns to IDLE.
// - Pipeline:
//   - Two registered stages: S1 ROM read, S2 multiply/shift into the output registers.
//   - Global enable en = !out_valid || out_ready; stall freezes every stage and the issue counter.
//   - Latency: start accepted at edge t, first out_valid at edge t+2.
//   - With out_ready held high, one beat per cycle and N*N consecutive beats.
// - Handshake:
//   - While out_valid=1 && out_ready=0, all outputs hold stable.
//   - out_valid never drops without acceptance.
// - start while busy=1 is ignored; k1/k2 changes while busy=1 have no effect.
// - A new start is accepted in the cycle done pulses (IDLE reached).
//   - Its first beat follows 2 cycles later; there is no bubble merging across sweeps.
// CONFIGURATION
// - DCT_COS_GEN_TRANSPOSE_EN defined:
//   - Adds input port col_major (1b), captured with k1/k2.
//   - col_major=1 issues in column-major order (n1 fastest).
//   - col_major=0 issues raster order.
//   - last still flags (N-1,N-1).
// - DCT_COS_GEN_TRANSPOSE_EN undefined:
//   - No col_major port; raster order only.
// TESTING
// - Defaults: reset held 2 cycles -> all outputs 0, busy=0.
//   - start with k1=0, k2=0, out_ready=1 -> 64 beats all 0x100; last only on beat 64; done 1 cycle later.
// - k1=0, k2=2, out_ready=1 -> n2=0..7 terms per row: 0xED, 0x62, -0x62, -0xED, -0xED, -0x62, 0x62, 0xED.
//   - Identical for every n1.
// - k1=7, k2=7, out_ready toggling 1/0 each cycle:
//   - Beats hold while stalled.
//   - Exactly 64 beats accepted, no duplicates.
//   - (0,0) term = (C[7][0]*C[7][0])>>>8 = (0x32*0x32)>>>8 = 0x09.
// - start pulsed again while busy, with different k -> ignored; stream continues with the original k.
//   - Follow-on start in the done cycle is accepted.
// - reset asserted mid-sweep (beat 20) while stalled -> next cycle out_valid=0, busy=0, no done pulse.
//   - A following start restarts at (0,0).
// - With DCT_COS_GEN_TRANSPOSE_EN, col_major=1, k1=1, k2=0:
//   - Beat order (0,0),(1,0),...,(7,0),(0,1)...
//   - Term values match the raster run per (n1,n2).

Source files
------------

// File: rtl/dct_cos_term_gen.sv
// Purpose: streams the N*N 2-D DCT basis terms C[k1][n1]*C[k2][n2] for one (k1,k2) pair. Optional build macro: DCT_COS_GEN_TRANSPOSE_EN adds col_major issue order.
// Latency: start accepted at edge t -> first out_valid at edge t+2, then one beat per cycle.
// Backpressure: en = !out_valid || out_ready; a stall freezes issue counters and both pipeline stages.
module dct_cos_term_gen #(
    parameter int N         = 8,
    parameter int FRAC_BITS = 8,
    parameter int OUT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [$clog2(N)-1:0] k1,
    input  logic [$clog2(N)-1:0] k2,
`ifdef DCT_COS_GEN_TRANSPOSE_EN
    input  logic                 col_major,
`endif
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     cos_term,
    output logic [$clog2(N)-1:0] n1,
    output logic [$clog2(N)-1:0] n2,
    output logic                 last,
    output logic                 done
);

    localparam int IW = $clog2(N);
    localparam int CW = FRAC_BITS + 2;
    localparam int PW = (OUT_W > 2 * CW) ? OUT_W : 2 * CW;

    // Cosine on [0, pi/2] by Taylor series; only ever evaluated at elaboration.
    function automatic real cos_q1(input real x);
        real t;
        real s;
        t = 1.0;
        s = 1.0;
        for (int j = 1; j <= 12; j++) begin
            t = -t * x * x / real'((2 * j - 1) * (2 * j));
            s = s + t;
        end
        return s;
    endfunction

    // Flattened table C[k][n], entry (k*N+n) is CW bits, rounded to nearest.
    function automatic logic [N*N*CW-1:0] build_rom();
        logic [N*N*CW-1:0] r;
        real               pi;
        real               sc;
        real               c;
        real               v;
        int                m;
        int                q;
        int                iv;
        bit                neg;
        pi = 3.14159265358979323846;
        sc = 1.0;
        r  = '0;
        for (int f = 0; f < FRAC_BITS; f++) sc = sc * 2.0;
        for (int k = 0; k < N; k++) begin
            for (int n = 0; n < N; n++) begin
                // Angle in units of pi/(2N), folded into the first quadrant.
                m   = ((2 * n + 1) * k) % (4 * N);
                neg = 1'b0;
                if (m <= N) begin
                    q = m;
                end else if (m <= 2 * N) begin
                    q   = 2 * N - m;
                    neg = 1'b1;
                end else if (m <= 3 * N) begin
                    q   = m - 2 * N;
                    neg = 1'b1;
                end else begin
                    q = 4 * N - m;
                end
                c = cos_q1(real'(q) * pi / real'(2 * N));
                if (neg) c = -c;
                v = c * sc;
                if (v >= 0.0) iv = $rtoi(v + 0.5);
                else          iv = -$rtoi(-v + 0.5);
                r[(k * N + n) * CW +: CW] = CW'(iv);
            end
        end
        return r;
    endfunction

    localparam logic [N*N*CW-1:0] ROM = build_rom();

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state;
    logic [IW-1:0]          k1_q;
    logic [IW-1:0]          k2_q;
    logic [IW-1:0]          i1;
    logic [IW-1:0]          i2;
    logic                   s1_vld;
    logic                   s1_last;
    logic [IW-1:0]          s1_n1;
    logic [IW-1:0]          s1_n2;
    logic signed [CW-1:0]   s1_ca;
    logic signed [CW-1:0]   s1_cb;
    logic signed [PW-1:0]   prod;
    logic                   en;
    logic                   at_end;
`ifdef DCT_COS_GEN_TRANSPOSE_EN
    logic                   cm_q;
`endif

    // Global pipeline enable, end-of-sweep detect and the full-width product.
    always_comb begin
        en     = !out_valid || out_ready;
        at_end = (i1 == IW'(N - 1)) && (i2 == IW'(N - 1));
        prod   = PW'(s1_ca) * PW'(s1_cb);
    end

    // Sweep control: capture k, walk the (n1,n2) issue counters, wait for the last acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            k1_q  <= '0;
            k2_q  <= '0;
            i1    <= '0;
            i2    <= '0;
`ifdef DCT_COS_GEN_TRANSPOSE_EN
            cm_q  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k1_q  <= k1;
                        k2_q  <= k2;
`ifdef DCT_COS_GEN_TRANSPOSE_EN
                        cm_q  <= col_major;
`endif
                        i1    <= '0;
                        i2    <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (en) begin
`ifdef DCT_COS_GEN_TRANSPOSE_EN
                        if (cm_q) begin
                            if (i1 == IW'(N - 1)) begin
                                i1 <= '0;
                                i2 <= i2 + 1'b1;
                            end else begin
                                i1 <= i1 + 1'b1;
                            end
                        end else
`endif
                        begin
                            if (i2 == IW'(N - 1)) begin
                                i2 <= '0;
                                i1 <= i1 + 1'b1;
                            end else begin
                                i2 <= i2 + 1'b1;
                            end
                        end
                        if (at_end) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready && last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1: look up both cosine factors for the issued position.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_n1   <= '0;
            s1_n2   <= '0;
            s1_ca   <= '0;
            s1_cb   <= '0;
        end else if (en) begin
            s1_vld  <= (state == RUN);
            s1_last <= (state == RUN) && at_end;
            s1_n1   <= i1;
            s1_n2   <= i2;
            s1_ca   <= ROM[(int'(k1_q) * N + int'(i1)) * CW +: CW];
            s1_cb   <= ROM[(int'(k2_q) * N + int'(i2)) * CW +: CW];
        end
    end

    // Stage 2: multiply, arithmetic shift back to FRAC_BITS, register the output beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            last      <= 1'b0;
            n1        <= '0;
            n2        <= '0;
            cos_term  <= '0;
        end else if (en) begin
            out_valid <= s1_vld;
            last      <= s1_vld && s1_last;
            n1        <= s1_n1;
            n2        <= s1_n2;
            cos_term  <= OUT_W'(prod >>> FRAC_BITS);
        end
    end

endmodule

// File: tb/tb_dct_cos_term_gen.sv
// Purpose: randomized/directed bench for dct_cos_term_gen against a real-arithmetic cosine model.
// Latency: expects first beat two edges after start acceptance and N*N beats per sweep.
// Backpressure: drives out_ready high, toggling or random and checks beats hold while stalled.
module tb_dct_cos_term_gen;

    localparam int N  = 8;
    localparam int NN = N * N;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  k1;
    logic [2:0]  k2;
`ifdef DCT_COS_GEN_TRANSPOSE_EN
    logic        col_major;
`endif
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] cos_term;
    logic [2:0]  n1;
    logic [2:0]  n2;
    logic        last;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;
    int k02_tab [8] = '{237, 98, -98, -237, -237, -98, 98, 237};

    dct_cos_term_gen dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .k1        (k1),
        .k2        (k2),
`ifdef DCT_COS_GEN_TRANSPOSE_EN
        .col_major (col_major),
`endif
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cos_term  (cos_term),
        .n1        (n1),
        .n2        (n2),
        .last      (last),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference cosine coefficient straight from the definition.
    function automatic int cref(input int k, input int n);
        real v;
        v = 256.0 * $cos(real'((2 * n + 1) * k) * 3.14159265358979323846 / 16.0);
        if (v >= 0.0) return $rtoi(v + 0.5);
        else          return -$rtoi(-v + 0.5);
    endfunction

    function automatic int term_ref(input int ka, input int kb, input int na, input int nb);
        int p;
        p = cref(ka, na) * cref(kb, nb);
        return p >>> 8;
    endfunction

    // One full sweep; mode 0 = ready high, 1 = toggling, 2 = random. Returns in the done cycle.
    task automatic sweep(input int ka, input int kb, input int mode, input int cm, input bit poke);
        int   beat;
        int   iter;
        int   e1;
        int   e2;
        logic pv;
        logic pr;
        start = 1'b1;
        k1    = 3'(ka);
        k2    = 3'(kb);
`ifdef DCT_COS_GEN_TRANSPOSE_EN
        col_major = cm[0];
`endif
        @(posedge clk); #1;
        start = 1'b0;
        k1    = 3'($urandom);
        k2    = 3'($urandom);
`ifdef DCT_COS_GEN_TRANSPOSE_EN
        col_major = 1'($urandom);
`endif
        chk("busy_on_start", 32'(busy), 1);
        chk("done_low_after_start", 32'(done), 0);
        chk("valid_t0", 32'(out_valid), 0);
        @(posedge clk); #1;
        chk("valid_t1", 32'(out_valid), 0);
        @(posedge clk); #1;
        chk("first_valid_t2", 32'(out_valid), 1);
        beat = 0;
        iter = 0;
        pv   = 1'b0;
        pr   = 1'b1;
        while (beat < NN && iter < 1000) begin
            if (pv && !pr) chk("hold_valid", 32'(out_valid), 1);
            chk("busy_run", 32'(busy), 1);
            chk("no_early_done", 32'(done), 0);
            if (out_valid) begin
                if (cm == 1) begin
                    e1 = beat % N;
                    e2 = beat / N;
                end else begin
                    e1 = beat / N;
                    e2 = beat % N;
                end
                chk("n1", 32'(n1), e1);
                chk("n2", 32'(n2), e2);
                chk("term", cos_term, term_ref(ka, kb, e1, e2));
                chk("last", 32'(last), 32'(beat == NN - 1));
                if (ka == 0 && kb == 0) chk("k00_const", cos_term, 256);
                if (ka == 0 && kb == 2) chk("k02_const", cos_term, k02_tab[e2]);
                if (ka == 7 && kb == 7 && beat == 0) chk("k77_origin", cos_term, 9);
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (iter % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = poke && (iter == 5 || iter == 6);
            k1    = 3'($urandom);
            k2    = 3'($urandom);
            pv    = out_valid;
            pr    = out_ready;
            if (out_valid && out_ready) beat++;
            iter++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("beats_accepted", beat, NN);
        if (mode == 0) chk("consecutive_beats", iter, NN);
        chk("done_pulse", 32'(done), 1);
        chk("busy_clear", 32'(busy), 0);
        chk("valid_clear", 32'(out_valid), 0);
    endtask

    initial begin
        int acc;
        int iter;
        reset     = 1'b1;
        start     = 1'b0;
        k1        = '0;
        k2        = '0;
        out_ready = 1'b0;
`ifdef DCT_COS_GEN_TRANSPOSE_EN
        col_major = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_last", 32'(last), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_term", cos_term, 0);
        chk("rst_n1", 32'(n1), 0);
        chk("rst_n2", 32'(n2), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        sweep(0, 0, 0, 0, 1'b0);
        sweep(0, 2, 0, 0, 1'b0);
        sweep(7, 7, 1, 0, 1'b0);
        sweep(5, 3, 2, 0, 1'b1);
        sweep($urandom_range(0, 7), $urandom_range(0, 7), 2, 0, 1'b0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 0);

        // Reset in the middle of a sweep while the output is stalled.
        start = 1'b1;
        k1    = 3'd1;
        k2    = 3'd3;
        @(posedge clk); #1;
        start = 1'b0;
        acc   = 0;
        iter  = 0;
        while (acc < 20 && iter < 500) begin
            out_ready = 1'b1;
            if (out_valid) acc++;
            iter++;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        chk("mid_accepted", acc, 20);
        chk("mid_stalled_valid", 32'(out_valid), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_term", cos_term, 0);
        @(posedge clk); #1;
        chk("mid_rst_no_done", 32'(done), 0);
        chk("mid_rst_idle", 32'(busy), 0);
        sweep(1, 3, 2, 0, 1'b0);

`ifdef DCT_COS_GEN_TRANSPOSE_EN
        sweep(1, 0, 0, 1, 1'b0);
        sweep(1, 0, 2, 0, 1'b0);
        sweep(2, 5, 2, 1, 1'b0);
`endif
        @(posedge clk); #1;
        chk("final_done_low", 32'(done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
